// File: rtl/axi_cfg_master.sv
// axi_cfg_master
//
// Single-beat AXI4 initiator for the accelerator configuration slave.
// Accepts one command at a time on a valid/ready stream, runs exactly one
// AW/W/B or AR/R exchange for it, and returns one response per command in
// command order.
//
// Ports:
//   clk, rst                 sole clock, synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake
//   cmd_write                1 = write, 0 = read
//   cmd_addr                 byte address
//   cmd_wdata, cmd_wstrb     write payload (ignored for reads)
//   rsp_valid / rsp_ready    response handshake
//   rsp_write                echo of the command direction
//   rsp_rdata                read data (0 for writes)
//   rsp_resp                 BRESP / RRESP as returned (SLVERR if rlast missing)
//   rsp_cycles               cycles from command acceptance to B/R handshake,
//                            saturating at 16'hFFFF
//   busy                     high whenever a command is being worked on
//   m_axi_*                  AXI4 master channels (AW, W, B, AR, R)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a new command
// WR_AW_W  | AW and W offered together, each drops after its handshake
// WR_B     | waiting for the write response
// RD_AR    | read address offered
// RD_R     | waiting for the read data beat
// RSP      | response held stable until rsp_ready

module axi_cfg_master #(
    parameter int AXI_ID_WIDTH    = 6,
    parameter int AXIL_ADDR_WIDTH = 40,
    parameter int AXIL_WIDTH      = 32,
    parameter int AXIL_STRB_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AXIL_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AXIL_WIDTH-1:0]      cmd_wdata,
    input  logic [AXIL_STRB_WIDTH-1:0] cmd_wstrb,

    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_write,
    output logic [AXIL_WIDTH-1:0]      rsp_rdata,
    output logic [1:0]                 rsp_resp,
    output logic [15:0]                rsp_cycles,

    output logic                       busy,

    output logic [AXI_ID_WIDTH-1:0]    m_axi_awid,
    output logic [AXIL_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]                 m_axi_awlen,
    output logic [2:0]                 m_axi_awsize,
    output logic [1:0]                 m_axi_awburst,
    output logic                       m_axi_awlock,
    output logic [3:0]                 m_axi_awcache,
    output logic [2:0]                 m_axi_awprot,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,

    output logic [AXIL_WIDTH-1:0]      m_axi_wdata,
    output logic [AXIL_STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                       m_axi_wlast,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,

    input  logic [AXI_ID_WIDTH-1:0]    m_axi_bid,
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready,

    output logic [AXI_ID_WIDTH-1:0]    m_axi_arid,
    output logic [AXIL_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic                       m_axi_arlock,
    output logic [3:0]                 m_axi_arcache,
    output logic [2:0]                 m_axi_arprot,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,

    input  logic [AXI_ID_WIDTH-1:0]    m_axi_rid,
    input  logic [AXIL_WIDTH-1:0]      m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready
);

    localparam logic [2:0] AXI_SIZE   = 3'($clog2(AXIL_STRB_WIDTH));
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_AW_W,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R,
        ST_RSP
    } state_t;

    state_t      state;
    logic        aw_done;
    logic        w_done;
    logic        aw_hs;
    logic        w_hs;
    logic        aw_fin;
    logic        w_fin;
    logic [15:0] cycles_inc;

    // Every beat is a single INCR transfer of the full bus width.
    assign m_axi_awid    = '0;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = AXI_SIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'd0;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_arid    = '0;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = AXI_SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;

    // Only one transaction is ever outstanding, so the returned IDs carry no
    // information.
    logic unused_ids;
    assign unused_ids = ^{m_axi_bid, m_axi_rid};

    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        aw_hs      = m_axi_awvalid && m_axi_awready;
        w_hs       = m_axi_wvalid && m_axi_wready;
        // A channel counts as finished if it completed earlier or completes now,
        // so AW and W may land in either order or together.
        aw_fin     = aw_done || aw_hs;
        w_fin      = w_done || w_hs;
        cycles_inc = (rsp_cycles == 16'hFFFF) ? rsp_cycles : rsp_cycles + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            rsp_cycles    <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        rsp_write  <= cmd_write;
                        rsp_cycles <= 16'd0;
                        if (cmd_write) begin
                            m_axi_awaddr  <= cmd_addr;
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_wstrb   <= cmd_wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= ST_WR_AW_W;
                        end else begin
                            m_axi_araddr  <= cmd_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= ST_RD_AR;
                        end
                    end
                end

                ST_WR_AW_W: begin
                    rsp_cycles <= cycles_inc;
                    if (aw_hs) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        m_axi_bready <= 1'b1;
                        state        <= ST_WR_B;
                    end
                end

                ST_WR_B: begin
                    rsp_cycles <= cycles_inc;
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_resp     <= m_axi_bresp;
                        rsp_rdata    <= '0;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end
                end

                ST_RD_AR: begin
                    rsp_cycles <= cycles_inc;
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= ST_RD_R;
                    end
                end

                ST_RD_R: begin
                    rsp_cycles <= cycles_inc;
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                        // A single-beat read must be the last beat; anything
                        // else means the slave misunderstood the request.
                        rsp_resp     <= m_axi_rlast ? m_axi_rresp : RESP_SLVERR;
                        rsp_valid    <= 1'b1;
                        state        <= ST_RSP;
                    end
                end

                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
